// File: rtl/pipeline_pkg.sv
// Shared encodings for the execute stage: ALU ops, aluop classes,
// forwarding-source select, R-type funct codes and branch funct3 codes.
package pipeline_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // {funct7[5], funct3} for R-type decode
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b1000;
    localparam logic [3:0] FN_AND = 4'b0111;
    localparam logic [3:0] FN_OR  = 4'b0110;
    localparam logic [3:0] FN_XOR = 4'b0100;
    localparam logic [3:0] FN_SLL = 4'b0001;
    localparam logic [3:0] FN_SRL = 4'b0101;
    localparam logic [3:0] FN_SRA = 4'b1101;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // EX/MEM has priority over MEM/WB; x0 is never a forwarding source.
    function automatic fwd_sel_e fwd_select(
        input logic       exmem_we,
        input logic [4:0] exmem_rd,
        input logic       memwb_we,
        input logic [4:0] memwb_rd,
        input logic [4:0] rs
    );
        if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs))
            return FWD_EXMEM;
        else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == rs))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/alu64.sv
// Combinational ALU; shifts use the low six bits of b, arithmetic wraps.
module alu64
    import pipeline_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_op_e           op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   result_o,
    output logic              zero_o
);

    logic [5:0] shamt;
    assign shamt = b_i[5:0];

    // Operation select
    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLL: result_o = a_i << shamt;
            ALU_SRL: result_o = a_i >> shamt;
            ALU_SRA: result_o = $signed(a_i) >>> shamt;
            default: result_o = a_i + b_i;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU decode, branch resolution
// and the EX/MEM pipeline register. Flush turns the registered
// instruction into a bubble by clearing its side-effecting controls.
module ex_mem_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [3:0]      funct_in,
    input  logic [1:0]      aluop_in,
    input  logic            memtoreg_in,
    input  logic            regwrite_in,
    input  logic            branch_in,
    input  logic            memwrite_in,
    input  logic            memread_in,
    input  logic            alusrc_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [4:0]      rd_in,
    input  logic            memwb_regwrite,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [XLEN-1:0] branch_target_out,
    output logic            zero_out,
    output logic            branch_taken_out,
    output logic            memtoreg_out,
    output logic            regwrite_out,
    output logic            memwrite_out,
    output logic            memread_out,
    output logic [4:0]      rd_out
);

    logic [XLEN-1:0] alu_result_q, store_data_q, branch_target_q;
    logic            zero_q, branch_taken_q, memtoreg_q, regwrite_q, memwrite_q, memread_q;
    logic [4:0]      rd_q;

    fwd_sel_e        fwd_a, fwd_b;
    logic [XLEN-1:0] op_a, op_b, alu_b;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic            cond_met;
    logic            branch_taken_d;
    logic [XLEN-1:0] branch_target_d;

    assign fwd_a = fwd_select(regwrite_q, rd_q, memwb_regwrite, memwb_rd, rs1_in);
    assign fwd_b = fwd_select(regwrite_q, rd_q, memwb_regwrite, memwb_rd, rs2_in);

    // Forwarding muxes for both register operands
    always_comb begin
        op_a = rs1_data_in;
        op_b = rs2_data_in;
        case (fwd_a)
            FWD_EXMEM: op_a = alu_result_q;
            FWD_MEMWB: op_a = memwb_wdata;
            default:   op_a = rs1_data_in;
        endcase
        case (fwd_b)
            FWD_EXMEM: op_b = alu_result_q;
            FWD_MEMWB: op_b = memwb_wdata;
            default:   op_b = rs2_data_in;
        endcase
    end

    assign alu_b = alusrc_in ? imm_in : op_b;

    // ALU control decode from aluop class and funct
    always_comb begin
        alu_op = ALU_ADD;
        case (aluop_in)
            ALUOP_SUB: alu_op = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_in)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

    alu64 #(.XLEN(XLEN)) u_alu (
        .op_i     (alu_op),
        .a_i      (op_a),
        .b_i      (alu_b),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    // Branch condition compares the forwarded register operands, never imm
    always_comb begin
        cond_met = 1'b0;
        case (funct_in[2:0])
            F3_BEQ:  cond_met = (op_a == op_b);
            F3_BNE:  cond_met = (op_a != op_b);
            F3_BLT:  cond_met = ($signed(op_a) <  $signed(op_b));
            F3_BGE:  cond_met = ($signed(op_a) >= $signed(op_b));
            default: cond_met = 1'b0;
        endcase
    end

    assign branch_taken_d  = branch_in & cond_met;
    assign branch_target_d = pc_in + (imm_in << 1);

    // EX/MEM register: reset clears all, flush clears only controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q    <= '0;
            store_data_q    <= '0;
            branch_target_q <= '0;
            zero_q          <= 1'b0;
            branch_taken_q  <= 1'b0;
            memtoreg_q      <= 1'b0;
            regwrite_q      <= 1'b0;
            memwrite_q      <= 1'b0;
            memread_q       <= 1'b0;
            rd_q            <= 5'd0;
        end else begin
            alu_result_q    <= alu_res;
            store_data_q    <= op_b;
            branch_target_q <= branch_target_d;
            zero_q          <= alu_zero;
            rd_q            <= rd_in;
            branch_taken_q  <= flush ? 1'b0 : branch_taken_d;
            memtoreg_q      <= flush ? 1'b0 : memtoreg_in;
            regwrite_q      <= flush ? 1'b0 : regwrite_in;
            memwrite_q      <= flush ? 1'b0 : memwrite_in;
            memread_q       <= flush ? 1'b0 : memread_in;
        end
    end

    assign alu_result_out    = alu_result_q;
    assign store_data_out    = store_data_q;
    assign branch_target_out = branch_target_q;
    assign zero_out          = zero_q;
    assign branch_taken_out  = branch_taken_q;
    assign memtoreg_out      = memtoreg_q;
    assign regwrite_out      = regwrite_q;
    assign memwrite_out      = memwrite_q;
    assign memread_out       = memread_q;
    assign rd_out            = rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with hand-computed expected values.
module tb_ex_mem_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [XLEN-1:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
    logic [3:0]      funct_in;
    logic [1:0]      aluop_in;
    logic            memtoreg_in, regwrite_in, branch_in, memwrite_in, memread_in, alusrc_in;
    logic [4:0]      rs1_in, rs2_in, rd_in;
    logic            memwb_regwrite;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_wdata;
    logic [XLEN-1:0] alu_result_out, store_data_out, branch_target_out;
    logic            zero_out, branch_taken_out, memtoreg_out, regwrite_out, memwrite_out, memread_out;
    logic [4:0]      rd_out;

    int vectors = 0;
    int miscompares = 0;

    ex_mem_stage #(.XLEN(XLEN)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .pc_in             (pc_in),
        .rs1_data_in       (rs1_data_in),
        .rs2_data_in       (rs2_data_in),
        .imm_in            (imm_in),
        .funct_in          (funct_in),
        .aluop_in          (aluop_in),
        .memtoreg_in       (memtoreg_in),
        .regwrite_in       (regwrite_in),
        .branch_in         (branch_in),
        .memwrite_in       (memwrite_in),
        .memread_in        (memread_in),
        .alusrc_in         (alusrc_in),
        .rs1_in            (rs1_in),
        .rs2_in            (rs2_in),
        .rd_in             (rd_in),
        .memwb_regwrite    (memwb_regwrite),
        .memwb_rd          (memwb_rd),
        .memwb_wdata       (memwb_wdata),
        .alu_result_out    (alu_result_out),
        .store_data_out    (store_data_out),
        .branch_target_out (branch_target_out),
        .zero_out          (zero_out),
        .branch_taken_out  (branch_taken_out),
        .memtoreg_out      (memtoreg_out),
        .regwrite_out      (regwrite_out),
        .memwrite_out      (memwrite_out),
        .memread_out       (memread_out),
        .rd_out            (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu"},   alu_result_out, 64'd0);
        chk({tag, ".store"}, store_data_out, 64'd0);
        chk({tag, ".tgt"},   branch_target_out, 64'd0);
        chk({tag, ".ctl"},   {58'd0, zero_out, branch_taken_out, memtoreg_out,
                              regwrite_out, memwrite_out, memread_out}, 64'd0);
        chk({tag, ".rd"},    {59'd0, rd_out}, 64'd0);
    endtask

    task automatic clr_in();
        flush = 0; pc_in = 0; rs1_data_in = 0; rs2_data_in = 0; imm_in = 0;
        funct_in = 0; aluop_in = 0; memtoreg_in = 0; regwrite_in = 0; branch_in = 0;
        memwrite_in = 0; memread_in = 0; alusrc_in = 0; rs1_in = 0; rs2_in = 0; rd_in = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // R-type op with no hazards: rs1=1, rs2=2, no writers pending
    task automatic rop(input string tag, input logic [3:0] fn, input logic [1:0] aop,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input logic exp_zero);
        clr_in();
        rs1_in = 5'd1; rs2_in = 5'd2; rs1_data_in = a; rs2_data_in = b;
        funct_in = fn; aluop_in = aop; rd_in = 5'd3;
        tick();
        chk({tag, ".res"},  alu_result_out, exp);
        chk({tag, ".zero"}, {63'd0, zero_out}, {63'd0, exp_zero});
    endtask

    task automatic br(input string tag, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] b, input logic exp_taken);
        clr_in();
        rs1_in = 5'd1; rs2_in = 5'd2; rs1_data_in = a; rs2_data_in = b;
        funct_in = {1'b0, f3}; aluop_in = 2'b01; branch_in = 1;
        pc_in = 64'h100; imm_in = 64'h8;
        tick();
        chk({tag, ".taken"}, {63'd0, branch_taken_out}, {63'd0, exp_taken});
        chk({tag, ".tgt"},   branch_target_out, 64'h110);
    endtask

    initial begin
        clr_in();
        reset = 1;
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 0;

        // Back-to-back RAW: add x5 = 3 + 4, then sub x5 - x0
        clr_in();
        rs1_in = 1; rs2_in = 2; rs1_data_in = 3; rs2_data_in = 4; rd_in = 5; regwrite_in = 1;
        tick();
        chk("raw1.res", alu_result_out, 64'd7);
        chk("raw1.rd",  {59'd0, rd_out}, 64'd5);
        chk("raw1.rw",  {63'd0, regwrite_out}, 64'd1);
        clr_in();
        rs1_in = 5; rs2_in = 0; rs1_data_in = 64'd99; rs2_data_in = 0;
        aluop_in = 2'b01; rd_in = 6; regwrite_in = 1;
        tick();
        chk("raw2.res", alu_result_out, 64'd7);

        // Double hazard: EX/MEM x5=10 wins over MEM/WB x5=20
        clr_in();
        rs1_in = 1; rs2_in = 2; rs1_data_in = 4; rs2_data_in = 6; rd_in = 5; regwrite_in = 1;
        tick();
        chk("dbl1.res", alu_result_out, 64'd10);
        clr_in();
        rs1_in = 5; rs2_in = 0; rs1_data_in = 1;
        memwb_regwrite = 1; memwb_rd = 5; memwb_wdata = 64'd20; rd_in = 8;
        tick();
        chk("dbl2.res", alu_result_out, 64'd10);

        // MEM/WB writing x0 must not forward; also clears EX/MEM writer
        clr_in();
        rs1_in = 0; rs2_in = 0; memwb_regwrite = 1; memwb_rd = 0; memwb_wdata = 64'h55;
        tick();
        chk("x0.res", alu_result_out, 64'd0);
        chk("x0.zero", {63'd0, zero_out}, 64'd1);

        // ALU decode
        rop("and",  4'b0111, 2'b10, 64'hF0, 64'h3C, 64'h30, 0);
        rop("or",   4'b0110, 2'b10, 64'hF0, 64'h3C, 64'hFC, 0);
        rop("xor",  4'b0100, 2'b10, 64'hF0, 64'h3C, 64'hCC, 0);
        rop("sll",  4'b0001, 2'b10, 64'h1, 64'h44, 64'h10, 0);
        rop("srl",  4'b0101, 2'b10, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 0);
        rop("sra",  4'b1101, 2'b10, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 0);
        rop("subr", 4'b1000, 2'b10, 64'd5, 64'd5, 64'd0, 1);
        rop("addw", 4'b0000, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
        rop("fdef", 4'b0010, 2'b10, 64'd9, 64'd3, 64'd12, 0);
        rop("aop3", 4'b1000, 2'b11, 64'd9, 64'd3, 64'd12, 0);
        rop("aop0", 4'b0111, 2'b00, 64'd9, 64'd3, 64'd12, 0);
        rop("aop1", 4'b0000, 2'b01, 64'd9, 64'd3, 64'd6, 0);

        // Branches
        br("beq", 3'b000, 64'h55, 64'h55, 1);
        br("bne", 3'b001, 64'h55, 64'h55, 0);
        br("blt", 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1);
        br("bge", 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        br("b2",  3'b010, 64'd1, 64'd1, 0);

        // Store forwarding from MEM/WB with immediate address
        clr_in();
        rs1_in = 1; rs1_data_in = 64'h1000; rs2_in = 7; rs2_data_in = 64'h1111;
        imm_in = 64'h20; alusrc_in = 1; memwrite_in = 1;
        memwb_regwrite = 1; memwb_rd = 7; memwb_wdata = 64'hDEAD;
        tick();
        chk("st.data", store_data_out, 64'hDEAD);
        chk("st.addr", alu_result_out, 64'h1020);
        chk("st.mw",   {63'd0, memwrite_out}, 64'd1);

        // Flush: controls cleared, data kept, no forwarding afterwards
        clr_in();
        rs1_in = 1; rs2_in = 2; rs1_data_in = 2; rs2_data_in = 3; rd_in = 9;
        regwrite_in = 1; memwrite_in = 1; memread_in = 1; memtoreg_in = 1; flush = 1;
        tick();
        chk("fl.rw",  {63'd0, regwrite_out}, 64'd0);
        chk("fl.mw",  {63'd0, memwrite_out}, 64'd0);
        chk("fl.mr",  {63'd0, memread_out}, 64'd0);
        chk("fl.m2r", {63'd0, memtoreg_out}, 64'd0);
        chk("fl.res", alu_result_out, 64'd5);
        chk("fl.rd",  {59'd0, rd_out}, 64'd9);
        clr_in();
        rs1_in = 9; rs1_data_in = 64'd100; rs2_in = 0;
        tick();
        chk("fl.nofwd", alu_result_out, 64'd100);

        // Async reset between edges, then reset with flush at an edge
        clr_in();
        rs1_in = 1; rs2_in = 2; rs1_data_in = 64'h33; rs2_data_in = 64'h11; rd_in = 4;
        regwrite_in = 1; memread_in = 1; pc_in = 64'h40; imm_in = 64'h2;
        tick();
        chk("pre.res", alu_result_out, 64'h44);
        chk("pre.tgt", branch_target_out, 64'h44);
        #2;
        reset = 1;
        #1;
        chk_all_zero("arst");
        flush = 1;
        tick();
        chk_all_zero("rstfl");
        reset = 0;
        flush = 0;
        rs1_in = 4; rs1_data_in = 64'h7;
        tick();
        chk("post.res", alu_result_out, 64'h18);
        chk("post.rw",  {63'd0, regwrite_out}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous bubble insert into EX/MEM.
REQ-005 SHALL have ports pc_in, rs1_data_in, rs2_data_in, imm_in  input  XLEN  from ID/EX.
REQ-006 SHALL have ports funct_in  input  4  {funct7[5],funct3}; aluop_in  input  2.
REQ-007 SHALL have ports memtoreg_in, regwrite_in, branch_in, memwrite_in, memread_in, alusrc_in  input  1  ID/EX control.
REQ-008 SHALL have ports rs1_in, rs2_in, rd_in  input  5  register indices.
REQ-009 SHALL have ports memwb_regwrite  input  1; memwb_rd  input  5; memwb_wdata  input  XLEN  MEM/WB forwarding source.
REQ-010 SHALL have ports alu_result_out, store_data_out, branch_target_out  output  XLEN.
REQ-011 SHALL have ports zero_out, branch_taken_out, memtoreg_out, regwrite_out, memwrite_out, memread_out  output  1.
REQ-012 SHALL have port rd_out  output  5.

Function
REQ-013 SHALL register all outputs on posedge clk; latency exactly one cycle from ID/EX inputs.
REQ-014 SHALL forward operand A: EX/MEM (regwrite_out=1, rd_out!=0, rd_out==rs1_in) -> alu_result_out; else MEM/WB (memwb_regwrite=1, memwb_rd!=0, match) -> memwb_wdata; else rs1_data_in.
REQ-015 SHALL forward operand B identically using rs2_in; EX/MEM always wins when both match.
REQ-016 SHALL use the forwarded rs2 value for store_data_out regardless of alusrc_in.
REQ-017 SHALL select ALU B = imm_in when alusrc_in=1, else forwarded rs2.
REQ-018 SHALL decode ALU op: aluop 00 -> ADD; 01 -> SUB; 10 -> by funct_in: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA, other ADD; aluop 11 -> ADD.
REQ-019 SHALL use B[5:0] as shift amount; arithmetic wraps modulo 2^XLEN, no overflow flag.
REQ-020 SHALL set zero_out = (ALU result == 0).
REQ-021 SHALL compute branch_target_out = pc_in + (imm_in << 1), truncated to XLEN.
REQ-022 SHALL set branch_taken_out = branch_in AND condition on funct_in[2:0]: 000 A==B, 001 A!=B, 100 A<B signed, 101 A>=B signed, else 0; A, B are forwarded register operands.
REQ-023 SHALL, on flush=1 at a clock edge, load regwrite/memwrite/memread/memtoreg/branch_taken outputs with 0 and hold data outputs at computed values.
REQ-024 SHALL never forward from rd=0; x0 reads stay rs*_data_in (expected 0).

Reset
REQ-025 SHALL clear every output to 0 immediately on reset=1, independent of clk.
REQ-026 SHALL give reset priority over flush; first edge after release samples normally.
REQ-027 SHALL not forward from EX/MEM on the first edge after reset (regwrite_out=0).

Structure
REQ-028 SHALL place ALU op encodings, aluop encodings, forwarding-select enum and branch funct3 constants in shared package pipeline_pkg.
REQ-029 SHALL implement the ALU as sub-module alu64 (op, a, b -> result, zero); forwarding, decode and EX/MEM register stay in ex_mem_stage.

Verification
REQ-030 SHALL test back-to-back RAW: add x5=3+4 then sub rs1=x5,rs2=x0 next cycle -> second alu_result_out = 7 via EX/MEM forward.
REQ-031 SHALL test double hazard: EX/MEM rd=5 value 10, memwb_rd=5 wdata 20, rs1_in=5 -> forwarded A = 10.
REQ-032 SHALL test branches: beq A=B=0x55 -> branch_taken_out=1, target = pc 0x100 + imm 0x8<<1 = 0x110; bne same operands -> 0; blt A=-1, B=1 -> 1.
REQ-033 SHALL test store forwarding: memwb_rd=7 wdata 0xDEAD, sd rs2=7 alusrc=1 -> store_data_out = 0xDEAD, alu_result_out = base+imm.
REQ-034 SHALL test flush with regwrite_in=1, memwrite_in=1 -> regwrite_out=0, memwrite_out=0; next cycle no EX/MEM forwarding.
REQ-035 SHALL test async reset mid-stream: assert between edges -> all outputs 0 before next posedge; reset+flush same edge -> reset result.
